// File: rtl/mjolnir_drv_if.sv
// Operand/result bundle between the adder test driver and its environment.
// slave is the driver's view; master is the environment (adder + control) view.
interface mjolnir_drv_if #(
  parameter int k = 64
);
  logic          start;
  logic [k-1:0]  seed;
  logic [15:0]   count;
  logic [k-1:0]  s_in;
  logic          cout_in;
  logic [k-1:0]  a;
  logic [k-1:0]  b;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   err_cnt;
  logic [15:0]   fail_idx;

  modport master (
    output start, seed, count, s_in, cout_in,
    input  a, b, busy, done, pass, err_cnt, fail_idx
  );

  modport slave (
    input  start, seed, count, s_in, cout_in,
    output a, b, busy, done, pass, err_cnt, fail_idx
  );
endinterface

// File: rtl/mjolnir_drv.sv
// Self-checking stimulus driver for a k-bit adder with LAT cycles of latency:
// launches count operand pairs, compares returned sums and reports the result.
module mjolnir_drv #(
  parameter int k   = 64,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mjolnir_drv_if.slave bus
);
  localparam logic [15:0] NO_FAIL = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [k-1:0]  a_q, a_d, b_q, b_d;
  logic [15:0]   cnt_q, cnt_d, idx_q, idx_d;
  logic [15:0]   err_cnt_q, err_cnt_d, fail_idx_q, fail_idx_d;
  logic          pass_q, pass_d;
  logic          launch, last_pair, chk_vld, chk_bad, last_chk;

  // Expected-result pipeline: stage 0 is loaded on the launch edge, stage LAT
  // lines up with the adder output sampled on the following edge.
  logic          pv_q [LAT+1];
  logic          pv_d [LAT+1];
  logic [k:0]    pe_q [LAT+1];
  logic [k:0]    pe_d [LAT+1];
  logic [15:0]   pi_q [LAT+1];
  logic [15:0]   pi_d [LAT+1];

  assign last_pair = (idx_q == cnt_q - 16'd1);
  assign chk_vld   = pv_q[LAT];
  assign chk_bad   = chk_vld && ({bus.cout_in, bus.s_in} != pe_q[LAT]);
  assign last_chk  = chk_vld && (pi_q[LAT] == cnt_q - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.count == 16'd0) ? DONE : RUN;
      RUN:     if (last_pair) state_d = DRAIN;
      DRAIN:   if (last_chk)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN) || (state_q == DRAIN);
    bus.done = (state_q == DONE);
    // In DONE the final count is already in err_cnt_q; pass_q holds it afterwards.
    bus.pass = (state_q == DONE) ? (err_cnt_q == 16'd0) : pass_q;
  end

  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.fail_idx = fail_idx_q;

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    err_cnt_d  = err_cnt_q;
    fail_idx_d = fail_idx_q;
    pass_d     = pass_q;
    launch     = 1'b0;
    if (chk_bad) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (fail_idx_q == NO_FAIL) fail_idx_d = pi_q[LAT];
    end
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d      = bus.count;
          idx_d      = 16'd0;
          err_cnt_d  = 16'd0;
          fail_idx_d = NO_FAIL;
          pass_d     = 1'b0;
          if (bus.count != 16'd0) begin
            a_d    = bus.seed;
            b_d    = ~bus.seed;
            launch = 1'b1;
          end
        end
      end
      RUN: begin
        if (!last_pair) begin
          a_d    = a_q + k'(1);
          b_d    = {b_q[k-2:0], b_q[k-1]};
          idx_d  = idx_q + 16'd1;
          launch = 1'b1;
        end
      end
      DONE:    pass_d = (err_cnt_q == 16'd0);
      default: ;
    endcase
  end

  always_comb begin
    pv_d[0] = launch;
    pe_d[0] = {1'b0, a_d} + {1'b0, b_d};
    pi_d[0] = idx_d;
    for (int j = 1; j <= LAT; j++) begin
      pv_d[j] = pv_q[j-1];
      pe_d[j] = pe_q[j-1];
      pi_d[j] = pi_q[j-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      err_cnt_q  <= '0;
      fail_idx_q <= NO_FAIL;
      pass_q     <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      err_cnt_q  <= err_cnt_d;
      fail_idx_q <= fail_idx_d;
      pass_q     <= pass_d;
    end
  end

  for (genvar gi = 0; gi <= LAT; gi++) begin : g_pipe
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv_q[gi] <= 1'b0;
        pe_q[gi] <= '0;
        pi_q[gi] <= '0;
      end else begin
        pv_q[gi] <= pv_d[gi];
        pe_q[gi] <= pe_d[gi];
        pi_q[gi] <= pi_d[gi];
      end
    end
  end
endmodule
